// File: rtl/mpu_host_mem.sv
// Purpose : host-memory quad-word read responder for MPU_OP_MLOAD; one request
//           becomes two 32-bit Wishbone classic reads (low word, then high word).
// Latency : request accepted on edge 0, LO beat cycle 1, HI beat cycle 2,
//           hm_done in cycle 3 with a zero-wait slave; each wait state adds one.
// Backpressure: hm_busy stalls instruction fetch while a request is pending or
//           in flight; the bus side waits on wb_ack_i / wb_err_i.
// Option  : define MPU_HM_TIMEOUT_EN to abort a beat after TIMEOUT wait cycles.
//
// Ports:
//   sys_clk, sys_rst_n          clock, async active-low reset
//   hm_start, hm_addr           level request + byte address (bits [2:0] ignored,
//                               bits [63:32] must be zero)
//   hm_data, hm_done, hm_err    registered result, one-cycle done strobe, error flag
//   hm_busy                     combinational fetch stall
//   wb_*                        Wishbone classic read master
module mpu_host_mem #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        hm_start,
   input  logic [63:0] hm_addr,
   output logic [63:0] hm_data,
   output logic        hm_busy,
   output logic        hm_done,
   output logic        hm_err,
   output logic [31:0] wb_adr_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state, state_d;
   logic [63:0] data_d;
   logic        err_d;
   logic        done_d;
   logic        cyc_d;
   logic [31:0] adr_d;
   logic        abort;

`ifdef MPU_HM_TIMEOUT_EN
   logic [7:0]  tmo_cnt, tmo_cnt_d;
   logic        unused_ok;
   assign unused_ok = ^hm_addr[2:0];
`else
   logic        unused_ok;
   assign unused_ok = ^{hm_addr[2:0], TIMEOUT};
`endif

   // Read-only master: fixed direction and full-word byte lanes.
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'hF;

   assign hm_busy = (state == ST_LO) | (state == ST_HI) | ((state == ST_IDLE) & hm_start);

   always_comb begin
      state_d = state;
      data_d  = hm_data;
      err_d   = hm_err;
      done_d  = 1'b0;
      cyc_d   = wb_cyc_o;
      adr_d   = wb_adr_o;
      abort   = 1'b0;
`ifdef MPU_HM_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (hm_start) begin
               if (hm_addr[63:32] == 32'd0) begin
                  state_d = ST_LO;
                  adr_d   = {hm_addr[31:3], 3'b000};
                  cyc_d   = 1'b1;
                  err_d   = 1'b0;
`ifdef MPU_HM_TIMEOUT_EN
                  tmo_cnt_d = 8'd0;
`endif
               end else begin
                  // Address outside the 32-bit bus: fail without touching the bus.
                  state_d = ST_DONE;
                  data_d  = '1;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         ST_LO, ST_HI: begin
            if (wb_err_i) begin
               abort = 1'b1;            // error beats a simultaneous ack
            end else if (wb_ack_i) begin
               if (state == ST_LO) begin
                  data_d[31:0] = wb_dat_i;
                  state_d      = ST_HI;
                  adr_d        = wb_adr_o + 32'd4;   // aligned, cannot wrap
`ifdef MPU_HM_TIMEOUT_EN
                  tmo_cnt_d    = 8'd0;
`endif
               end else begin
                  data_d[63:32] = wb_dat_i;
                  state_d       = ST_DONE;
                  cyc_d         = 1'b0;
                  done_d        = 1'b1;
               end
            end else begin
`ifdef MPU_HM_TIMEOUT_EN
               // Abort on the wait cycle in which the count reaches TIMEOUT.
               tmo_cnt_d = tmo_cnt + 8'd1;
               if (tmo_cnt_d == TIMEOUT) abort = 1'b1;
`endif
            end
            if (abort) begin
               state_d = ST_DONE;
               data_d  = '1;
               err_d   = 1'b1;
               cyc_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;           // hm_start ignored here
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         hm_data  <= 64'd0;
         hm_done  <= 1'b0;
         hm_err   <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_adr_o <= 32'd0;
`ifdef MPU_HM_TIMEOUT_EN
         tmo_cnt  <= 8'd0;
`endif
      end else begin
         state    <= state_d;
         hm_data  <= data_d;
         hm_done  <= done_d;
         hm_err   <= err_d;
         wb_cyc_o <= cyc_d;
         wb_stb_o <= cyc_d;           // strobe held for the whole two-beat cycle
         wb_adr_o <= adr_d;
`ifdef MPU_HM_TIMEOUT_EN
         tmo_cnt  <= tmo_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_mpu_host_mem.sv
module tb_mpu_host_mem;

`ifdef MPU_HM_TIMEOUT_EN
   localparam logic [7:0] TO_P = 8'd4;
`else
   localparam logic [7:0] TO_P = 8'd255;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        hm_start;
   logic [63:0] hm_addr;
   logic [63:0] hm_data;
   logic        hm_busy, hm_done, hm_err;
   logic [31:0] wb_adr_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i;

   // Slave behaviour knobs
   logic        slv_ack, slv_err_hi;
   logic [31:0] slv_lo, slv_hi;

   int checks = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   mpu_host_mem #(.TIMEOUT(TO_P)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .hm_start(hm_start), .hm_addr(hm_addr),
      .hm_data(hm_data), .hm_busy(hm_busy), .hm_done(hm_done), .hm_err(hm_err),
      .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Zero-wait slave answering the beat currently on the bus.
   task automatic slave_drive();
      wb_ack_i = slv_ack & wb_cyc_o & wb_stb_o;
      wb_err_i = slv_err_hi & wb_cyc_o & wb_stb_o & wb_adr_o[2];
      wb_dat_i = wb_adr_o[2] ? slv_hi : slv_lo;
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      slave_drive();
   endtask

   task automatic do_read(input string tag, input logic [63:0] addr,
                          input logic [31:0] lo, input logic [31:0] hi);
      int n;
      slv_lo = lo; slv_hi = hi; slv_ack = 1'b1; slv_err_hi = 1'b0;
      hm_addr = addr; hm_start = 1'b1;
      n = 0;
      while (!hm_done && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, {63'd0, hm_done}, 64'd1);
      chk({tag, "_data"}, hm_data, {hi, lo});
      chk({tag, "_err"},  {63'd0, hm_err}, 64'd0);
      hm_start = 1'b0;
      tick();
   endtask

   initial begin
      int done_cnt;
      int done_at;
      logic saw_2008;

      sys_rst_n = 1'b0; hm_start = 1'b0; hm_addr = 64'd0;
      wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      slv_ack = 1'b0; slv_err_hi = 1'b0; slv_lo = 32'd0; slv_hi = 32'd0;
      #23;
      chk("rst_data", hm_data, 64'd0);
      chk("rst_flags", {60'd0, hm_done, hm_err, wb_cyc_o, wb_stb_o}, 64'd0);
      chk("rst_adr", {32'd0, wb_adr_o}, 64'd0);
      chk("rst_busy", {63'd0, hm_busy}, 64'd0);
      chk("const_we_sel", {59'd0, wb_we_o, wb_sel_o}, 64'h0F);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      tick();

      // Stray ack while idle is ignored
      wb_ack_i = 1'b1;
      tick();
      chk("stray_ack", {61'd0, hm_done, wb_cyc_o, hm_busy}, 64'd0);

      // Zero-wait read
      slv_ack = 1'b1; slv_lo = 32'hDEADBEEF; slv_hi = 32'hCAFEF00D;
      hm_addr = 64'h1000; hm_start = 1'b1;
      #1;
      chk("zw_busy_c0", {63'd0, hm_busy}, 64'd1);
      tick();
      chk("zw_c1", {61'd0, wb_cyc_o, wb_stb_o, hm_busy}, 64'h7);
      chk("zw_adr_lo", {32'd0, wb_adr_o}, 64'h1000);
      tick();
      chk("zw_c2", {61'd0, wb_cyc_o, hm_busy, hm_done}, 64'h6);
      chk("zw_adr_hi", {32'd0, wb_adr_o}, 64'h1004);
      tick();
      chk("zw_c3", {60'd0, hm_done, hm_err, wb_cyc_o, hm_busy}, 64'h8);
      chk("zw_data", hm_data, 64'hCAFEF00D_DEADBEEF);
      hm_start = 1'b0;
      tick();
      chk("zw_c4", {62'd0, hm_done, wb_cyc_o}, 64'd0);

      // Back-to-back MLOADs with hm_start held high
      hm_addr = 64'h1000; hm_start = 1'b1;
      slv_lo = 32'h11111111; slv_hi = 32'h22222222;
      done_cnt = 0; done_at = 0; saw_2008 = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 4) begin
            hm_addr = 64'h2008;
            slv_lo = 32'h33333333; slv_hi = 32'h44444444;
            slave_drive();
         end
         if (wb_cyc_o && wb_adr_o == 32'h2008) saw_2008 = 1'b1;
         if (hm_done) begin
            done_cnt++;
            if (done_cnt == 2) begin
               done_at = i;
               chk("b2b_data2", hm_data, 64'h44444444_33333333);
               hm_start = 1'b0;
            end
         end
      end
      chk("b2b_pulses", done_cnt, 2);
      chk("b2b_saw_2008", {63'd0, saw_2008}, 64'd1);
      chk("b2b_done_cycle", done_at, 7);

      // Bus error on the HI beat (ack raised too: error must win)
      slv_err_hi = 1'b1; hm_addr = 64'h3000; hm_start = 1'b1;
      tick();
      tick();
      chk("berr_hi_beat", {61'd0, wb_cyc_o, wb_err_i, wb_adr_o[2]}, 64'h7);
      tick();
      chk("berr_flags", {61'd0, hm_done, hm_err, wb_cyc_o}, 64'h6);
      chk("berr_data", hm_data, 64'hFFFF_FFFF_FFFF_FFFF);
      hm_start = 1'b0; slv_err_hi = 1'b0;
      tick();

      // Bad address: no bus access, done+err in cycle 1
      hm_addr = 64'h1_0000_0000; hm_start = 1'b1;
      #1;
      chk("bad_busy_c0", {63'd0, hm_busy}, 64'd1);
      tick();
      chk("bad_c1", {61'd0, hm_done, hm_err, wb_cyc_o}, 64'h6);
      chk("bad_data", hm_data, 64'hFFFF_FFFF_FFFF_FFFF);
      hm_start = 1'b0;
      tick();
      chk("bad_c2", {61'd0, hm_done, hm_err, wb_cyc_o}, 64'h2);

      // A good read clears the held error
      do_read("clr_err", 64'h0000_0000_8000_0010, 32'h0BADF00D, 32'h12345678);

      // Reset in the middle of LO with a silent slave
      slv_ack = 1'b0; hm_addr = 64'h4000; hm_start = 1'b1;
      tick();
      tick();
      chk("rmid_lo", {62'd0, wb_cyc_o, hm_busy}, 64'h3);
      hm_start = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      chk("rmid_drop", {60'd0, wb_cyc_o, wb_stb_o, hm_busy, hm_done}, 64'd0);
      tick();
      sys_rst_n = 1'b1;
      tick();
      do_read("rmid_fresh", 64'h5000, 32'hA5A5A5A5, 32'h5A5A5A5A);

`ifdef MPU_HM_TIMEOUT_EN
      // Silent slave with TIMEOUT=4: four LO wait cycles, abort in cycle 5
      slv_ack = 1'b0; hm_addr = 64'h6000; hm_start = 1'b1;
      for (int i = 1; i <= 4; i++) tick();
      chk("tmo_c4", {62'd0, wb_cyc_o, hm_done}, 64'h2);
      tick();
      chk("tmo_c5", {61'd0, hm_done, hm_err, wb_cyc_o}, 64'h6);
      chk("tmo_data", hm_data, 64'hFFFF_FFFF_FFFF_FFFF);
      hm_start = 1'b0;
      tick();
      chk("tmo_c6", {62'd0, wb_cyc_o, hm_done}, 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
